// File: rtl/lsu_wb_if.sv
// lsu_wb_if: decode request, memory bus and writeback signals of lsu_wb.
// misalign_err exists only when LSU_MISALIGN_TRAP_EN is defined.
interface lsu_wb_if;
  logic        req_valid, req_ready, req_is_load, req_is_store;
  logic [2:0]  funct3;
  logic [31:0] base_addr, offset, store_data;
  logic [4:0]  rd;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        store_done, bus_err, busy;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign_err;
`endif
  modport master (
    input  req_valid, req_is_load, req_is_store, funct3, base_addr, offset, store_data, rd,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output wb_valid, wb_rd, wb_data, store_done, bus_err, busy
`ifdef LSU_MISALIGN_TRAP_EN
    , output misalign_err
`endif
  );
  modport slave (
    output req_valid, req_is_load, req_is_store, funct3, base_addr, offset, store_data, rd,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  wb_valid, wb_rd, wb_data, store_done, bus_err, busy
`ifdef LSU_MISALIGN_TRAP_EN
    , input misalign_err
`endif
  );
endinterface

// File: rtl/lsu_wb.sv
// lsu_wb: single-outstanding RV32I load/store unit over a req/gnt/rvalid bus with a one-cycle writeback.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of forcing their low address bits.
module lsu_wb #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W = 32
) (
  input logic clk,
  input logic rst_n,
  lsu_wb_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, WB} state_t;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
  state_t state;
  logic [ADDR_W-1:0] addr, sum, eff;
  logic [2:0] f3;
  logic [4:0] rd;
  logic [CW-1:0] cnt;
  logic go, legal, trap, to;
  logic [1:0] sz;
  logic [3:0] strb;
  logic [31:0] wdata, ld;
  logic [7:0] lb;
  logic [15:0] lh;
  assign go = bus.req_valid && state == IDLE && (bus.req_is_load ^ bus.req_is_store);
  assign sz = bus.funct3[1:0];
  assign sum = ADDR_W'(bus.base_addr + bus.offset);
  assign legal = bus.req_is_load ? !(bus.funct3 inside {3'b011, 3'b110, 3'b111}) : bus.funct3 < 3'd3;
`ifdef LSU_MISALIGN_TRAP_EN
  logic mis;
  assign mis = (sz == 2'b01 && sum[0]) || (sz == 2'b10 && sum[1:0] != 2'b00);
  assign trap = !legal || mis;
  assign eff = sum;
`else
  assign trap = !legal;
  assign eff = sz == 2'b01 ? {sum[ADDR_W-1:1], 1'b0} : sz == 2'b10 ? {sum[ADDR_W-1:2], 2'b00} : sum;
`endif
  assign strb = sz == 2'b00 ? 4'b0001 << eff[1:0] : sz == 2'b01 ? (eff[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wdata = sz == 2'b00 ? {4{bus.store_data[7:0]}} : sz == 2'b01 ? {2{bus.store_data[15:0]}} : bus.store_data;
  assign lb = bus.mem_rdata[{addr[1:0], 3'b000} +: 8];
  assign lh = bus.mem_rdata[{addr[1], 4'b0000} +: 16];
  assign ld = f3[1:0] == 2'b00 ? {{24{lb[7] & ~f3[2]}}, lb} :
              f3[1:0] == 2'b01 ? {{16{lh[15] & ~f3[2]}}, lh} : bus.mem_rdata;
  // cnt is cleared on entry to REQ/WAIT_R, so it counts cycles spent in the current wait state
  assign to = TIMEOUT_CYCLES != 0 && int'(cnt) == TIMEOUT_CYCLES - 1;
  assign bus.mem_addr = 32'({addr[ADDR_W-1:2], 2'b00});
  assign bus.req_ready = state == IDLE;
  assign bus.busy = state != IDLE;
  assign bus.store_done = state == REQ && bus.mem_we && bus.mem_gnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      addr <= '0;
      f3 <= '0;
      rd <= '0;
      cnt <= '0;
      bus.mem_req <= 1'b0;
      bus.mem_we <= 1'b0;
      bus.mem_wdata <= '0;
      bus.mem_wstrb <= '0;
      bus.wb_valid <= 1'b0;
      bus.wb_rd <= '0;
      bus.wb_data <= '0;
      bus.bus_err <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      bus.misalign_err <= 1'b0;
`endif
    end else begin
      bus.bus_err <= 1'b0;
      bus.wb_valid <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      bus.misalign_err <= 1'b0;
`endif
      cnt <= cnt + 1'b1;
      case (state)
        IDLE: if (go) begin
          if (trap) begin
            bus.bus_err <= 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
            bus.misalign_err <= legal && mis;
`endif
          end else begin
            state <= REQ;
            cnt <= '0;
            addr <= eff;
            f3 <= bus.funct3;
            rd <= bus.rd;
            bus.mem_req <= 1'b1;
            bus.mem_we <= bus.req_is_store;
            bus.mem_wstrb <= bus.req_is_store ? strb : 4'b0000;
            bus.mem_wdata <= wdata;
          end
        end
        REQ: if (bus.mem_gnt) begin
          bus.mem_req <= 1'b0;
          state <= bus.mem_we ? IDLE : WAIT_R;
          cnt <= '0;
        end else if (to) begin
          bus.mem_req <= 1'b0;
          bus.bus_err <= 1'b1;
          state <= IDLE;
        end
        WAIT_R: if (bus.mem_rvalid) begin
          state <= WB;
          bus.wb_valid <= rd != 5'd0;
          bus.wb_rd <= rd;
          bus.wb_data <= ld;
        end else if (to) begin
          bus.bus_err <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule
